logistic_seq_ctrl: RTL and testbench
====================================

# logistic_seq_ctrl

Sequencer for the `logistic` chaotic-map datapath: x(n+1) = 4·x(n)·(1−x(n)) in Q0.32. It accepts a seed/warm-up/length configuration through a valid/ready handshake and iterates the map, feeding each result back into the datapath. It discards the warm-up iterations, then streams the requested number of 32-bit keystream words over a valid/ready output with backpressure. It sits between the key-schedule/config logic and the cipher XOR stage.

## Interface
- CNT_W, 16, width of warm-up and length counters
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  high only in IDLE
- cfg_seed  in  32  initial x, Q0.32
- cfg_warmup  in  CNT_W  iterations to discard
- cfg_length  in  CNT_W  words to emit
- abort  in  1  synchronous cancel
- ks_valid  out  1  keystream word available
- ks_ready  in  1  consumer accepts word
- ks_data  out  32  keystream word (current x)
- ks_last  out  1  marks final word of run, qualified by ks_valid
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse after final handshake
- err_cfg  out  1  sticky; set on rejected config, cleared on next accepted config or rst

## Operation
- Datapath: one `logistic` instance; xl = x_cur (32-bit register owned by this block); result xln is valid 1 cycle after xl changes; captured value = xln[31:0] (bit 32 never set, because the datapath maps 0x8000_0000 to 0xFFFF_FFFF and 0xC000_0000 to 0xBFFF_FFFF).
- States: IDLE, WARM, RUN, EMIT.
- IDLE: cfg_ready=1. When cfg_valid=1:
  - Reject if cfg_seed==0 (fixed point 0) or cfg_length==0: set err_cfg, stay IDLE.
  - Otherwise: x_cur<=cfg_seed, wcnt<=cfg_warmup, ocnt<=cfg_length, phase<=0, err_cfg<=0. Next state is WARM, or RUN if cfg_warmup==0.
- Iteration: 2 cycles. Phase 0 lets the datapath register f(x_cur). In phase 1, x_cur<=xln[31:0].
- WARM: on each phase-1 capture, wcnt decrements. The capture that brings wcnt to 0 moves the FSM to RUN, phase 0.
- RUN: one iteration. On phase-1 capture, go to EMIT.
- EMIT: ks_valid=1, ks_data=x_cur, ks_last=(ocnt==1). Hold x_cur while ks_ready=0.
  - On handshake, ocnt decrements.
  - If last: go to IDLE and pulse done on the following cycle.
  - Otherwise: go to RUN, phase 0.
- abort (any state except IDLE): next state IDLE; ks_valid drops the next cycle; no done; err_cfg unchanged. Abort has priority over a same-cycle handshake; the word counts as not transferred.
- cfg_valid while busy: ignored (cfg_ready=0).
- Reset: datapath rst_n driven by ~rst.

## Timing
- Reset values: state=IDLE, x_cur=0, cfg_ready=1; ks_valid, ks_last, ks_data, busy, done, err_cfg all 0.
- Edge E0 is the cfg handshake. First ks_valid asserts in the cycle following edge E0+2+2·warmup.
- With ks_ready held high: one word every 3 cycles (2 compute + 1 emit).
- ks_data/ks_valid/ks_last are stable while ks_valid=1 and ks_ready=0 (AXI-stream rule).
- rst mid-run: all outputs reach reset values on the next cycle; the datapath output is cleared.
- Counters are CNT_W-bit unsigned; cfg_warmup=2^CNT_W−1 must run the full count with no wrap.

## Structure
- Package logistic_ctrl_pkg contains:
  - state_t enum {IDLE, WARM, RUN, EMIT}
  - XW=32
  - SEED_ZERO=32'h0
  - FIX_075=32'hC000_0000 and FIX_050=32'h8000_0000 (for bench reference model)
- Sub-module: the existing `logistic`, instantiated once. No further hierarchy.

## Test plan
- Seed 0x4000_0000, warmup 0, length 3, ks_ready=1 -> words 0xC000_0000, 0xBFFF_FFFF, 0xC000_0001; ks_last on the third; done one cycle after.
- Seed 0x8000_0000, warmup 1, length 2 -> first word 0x0000_0003 (0xFFFF_FFFF discarded), then 0x0000_000B.
- Seed 0 or length 0 -> cfg_ready stays 1, err_cfg=1, busy=0. A following valid config clears err_cfg.
- Seed 0x4000_0000, length 3, ks_ready low for 5 cycles per word -> ks_data stable while stalled; sequence identical to test 1.
- abort asserted during WARM, and separately in EMIT with ks_ready=1 -> IDLE next cycle, no done, no ks_last; a new config restarts cleanly.
- rst pulsed mid-EMIT -> all outputs at reset values next cycle. Rerun of test 1 afterwards matches exactly.

Source files
------------

// File: rtl/logistic_ctrl_pkg.sv
// Shared types and constants for the logistic-map
// keystream sequencer and its datapath.
package logistic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WARM,
    RUN,
    EMIT
  } state_t;

  localparam int          XW        = 32;
  localparam logic [31:0] SEED_ZERO = 32'h0;
  localparam logic [31:0] FIX_075   = 32'hC000_0000;
  localparam logic [31:0] FIX_050   = 32'h8000_0000;

endpackage

// File: rtl/logistic.sv
// Logistic map datapath: xln = 4*x*(1-x) in Q0.32,
// registered, with escapes from the 1.0 and 0.75 traps.
module logistic
  import logistic_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [XW-1:0] xl,
  output logic [XW:0]   xln
);

  logic [XW:0]     one_m_x;
  logic [2*XW+1:0] prod;
  logic [XW:0]     y;
  logic [XW:0]     f;

  // 1.0 saturates to all-ones; the 0.75 fixed point is nudged down
  always_comb begin
    one_m_x = {1'b1, {XW{1'b0}}} - {1'b0, xl};
    prod    = {{(XW+2){1'b0}}, xl} * {{(XW+1){1'b0}}, one_m_x};
    y       = (XW+1)'(prod >> (XW-2));
    f       = y;
    if (y[XW]) begin
      f = {1'b0, {XW{1'b1}}};
    end else if (y[XW-1:0] == xl && xl != SEED_ZERO) begin
      f = {1'b0, xl - XW'(1)};
    end
  end

  // One-cycle result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xln <= '0;
    else        xln <= f;
  end

endmodule

// File: rtl/logistic_seq_ctrl.sv
// Sequencer: config handshake, warm-up discard and
// backpressured keystream emission from the logistic map.
module logistic_seq_ctrl
  import logistic_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [XW-1:0]    cfg_seed,
  input  logic [CNT_W-1:0] cfg_warmup,
  input  logic [CNT_W-1:0] cfg_length,
  input  logic             abort,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic [XW-1:0]    ks_data,
  output logic             ks_last,
  output logic             busy,
  output logic             done,
  output logic             err_cfg
);

  state_t           state;
  logic [XW-1:0]    x_cur;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] ocnt;
  logic             phase;
  logic             dp_rst_n;
  logic [XW:0]      xln;
  logic             xln_unused;

  assign dp_rst_n   = ~rst;
  assign ks_data    = x_cur;
  assign xln_unused = xln[XW];

  logistic u_dp (
    .clk   (clk),
    .rst_n (dp_rst_n),
    .xl    (x_cur),
    .xln   (xln)
  );

  // Control FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x_cur     <= '0;
      wcnt      <= '0;
      ocnt      <= '0;
      phase     <= 1'b0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      ks_valid  <= 1'b0;
      ks_last   <= 1'b0;
      done      <= 1'b0;
      err_cfg   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state     <= IDLE;
        phase     <= 1'b0;
        cfg_ready <= 1'b1;
        busy      <= 1'b0;
        ks_valid  <= 1'b0;
        ks_last   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (cfg_valid) begin
              if (cfg_seed == SEED_ZERO || cfg_length == '0) begin
                err_cfg <= 1'b1;
              end else begin
                x_cur     <= cfg_seed;
                wcnt      <= cfg_warmup;
                ocnt      <= cfg_length;
                phase     <= 1'b0;
                err_cfg   <= 1'b0;
                cfg_ready <= 1'b0;
                busy      <= 1'b1;
                state     <= (cfg_warmup == '0) ? RUN : WARM;
              end
            end
          end
          WARM: begin
            phase <= ~phase;
            if (phase) begin
              x_cur <= xln[XW-1:0];
              wcnt  <= wcnt - CNT_W'(1);
              if (wcnt == CNT_W'(1)) state <= RUN;
            end
          end
          RUN: begin
            phase <= ~phase;
            if (phase) begin
              x_cur    <= xln[XW-1:0];
              state    <= EMIT;
              ks_valid <= 1'b1;
              ks_last  <= (ocnt == CNT_W'(1));
            end
          end
          EMIT: begin
            if (ks_ready) begin
              ocnt     <= ocnt - CNT_W'(1);
              ks_valid <= 1'b0;
              ks_last  <= 1'b0;
              if (ocnt == CNT_W'(1)) begin
                state     <= IDLE;
                done      <= 1'b1;
                cfg_ready <= 1'b1;
                busy      <= 1'b0;
              end else begin
                state <= RUN;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_logistic_seq_ctrl.sv
// Scoreboard bench for logistic_seq_ctrl: directed
// cases plus randomized runs against a map model.
module tb_logistic_seq_ctrl;
  import logistic_ctrl_pkg::*;

  logic        clk = 0;
  logic        rst = 1;
  logic        cfg_valid = 0;
  logic        cfg_ready;
  logic [31:0] cfg_seed = 0;
  logic [15:0] cfg_warmup = 0;
  logic [15:0] cfg_length = 0;
  logic        abort = 0;
  logic        ks_valid;
  logic        ks_ready = 0;
  logic [31:0] ks_data;
  logic        ks_last;
  logic        busy;
  logic        done;
  logic        err_cfg;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int rdy_mode = 0;
  int stall_cnt = 0;

  logic [32:0] exp_q[$];
  logic        stall_q = 0;
  logic [31:0] prev_d;
  logic        prev_l;

  logistic_seq_ctrl #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_seed   (cfg_seed),
    .cfg_warmup (cfg_warmup),
    .cfg_length (cfg_length),
    .abort      (abort),
    .ks_valid   (ks_valid),
    .ks_ready   (ks_ready),
    .ks_data    (ks_data),
    .ks_last    (ks_last),
    .busy       (busy),
    .done       (done),
    .err_cfg    (err_cfg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // x -> floor(4x(1-x)) in Q0.32; 1.0 saturates, 0.75 steps off itself
  function automatic logic [31:0] f_map(input logic [31:0] x);
    longint unsigned p;
    longint unsigned y;
    p = longint'(x) * ((64'd1 << 32) - longint'(x));
    y = p / (64'd1 << 30);
    if (y >= (64'd1 << 32)) return 32'hFFFF_FFFF;
    if (y == longint'(x) && x != 0) return x - 1;
    return y[31:0];
  endfunction

  task automatic model_push(input logic [31:0] s, input int w,
                            input int l);
    logic [31:0] x;
    x = s;
    repeat (w) x = f_map(x);
    for (int i = 0; i < l; i++) begin
      x = f_map(x);
      exp_q.push_back({(i == l - 1), x});
    end
  endtask

  task automatic push_word(input logic [31:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  // ks_ready pattern generator
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: ks_ready = 1'b1;
      1: begin
        ks_ready  = (stall_cnt == 5);
        stall_cnt = (stall_cnt == 5) ? 0 : stall_cnt + 1;
      end
      default: ks_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pop on handshake, check stall stability, count done
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && stall_q && ks_valid) begin
      chk("stall_data", ks_data, prev_d);
      chk("stall_last", ks_last, prev_l);
    end
    if (!rst && !abort && ks_valid && ks_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", ks_data, 64'hX);
      end else begin
        e = exp_q.pop_front();
        chk("ks_data", ks_data, e[31:0]);
        chk("ks_last", ks_last, e[32]);
      end
    end
    stall_q = ks_valid && !ks_ready && !abort && !rst;
    prev_d  = ks_data;
    prev_l  = ks_last;
    if (done) done_cnt++;
  end

  task automatic cfg(input logic [31:0] s, input logic [15:0] w,
                     input logic [15:0] l);
    int n;
    n = 0;
    while (!cfg_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cfg_ready_wait", cfg_ready, 1);
    cfg_valid  = 1;
    cfg_seed   = s;
    cfg_warmup = w;
    cfg_length = l;
    @(posedge clk); #1;
    cfg_valid = 0;
  endtask

  task automatic wait_run(input string nm, input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    chk({nm, "_done_seen"}, got, 1);
    if (got) begin
      chk({nm, "_q_empty"}, exp_q.size(), 0);
      chk({nm, "_valid_at_done"}, ks_valid, 0);
      chk({nm, "_busy_at_done"}, busy, 0);
      @(negedge clk);
      chk({nm, "_done_pulse"}, done, 0);
    end
    exp_q.delete();
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!ks_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("valid_wait", ks_valid, 1);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_cfg_ready"}, cfg_ready, 1);
    chk({nm, "_ks_valid"}, ks_valid, 0);
    chk({nm, "_ks_last"}, ks_last, 0);
    chk({nm, "_ks_data"}, ks_data, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err_cfg"}, err_cfg, 0);
  endtask

  task automatic run_t1(input string nm);
    push_word(FIX_075, 0);
    push_word(FIX_075 - 1, 0);
    push_word(FIX_075 + 1, 1);
    cfg(32'h4000_0000, 0, 3);
    wait_run(nm, 100);
  endtask

  initial begin
    int d0;
    logic [31:0] s;
    int w;
    int l;

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk_reset_outs("reset");

    // Test 1 with first-word latency
    rdy_mode = 0;
    push_word(FIX_075, 0);
    push_word(FIX_075 - 1, 0);
    push_word(FIX_075 + 1, 1);
    cfg(32'h4000_0000, 0, 3);
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_cfg_ready", cfg_ready, 0);
    chk("t1_lat0", ks_valid, 0);
    @(negedge clk);
    chk("t1_lat1", ks_valid, 0);
    @(negedge clk);
    chk("t1_lat2", ks_valid, 1);
    wait_run("t1", 100);

    // Test 2: saturation at 1.0 during warm-up
    push_word(32'h0000_0003, 0);
    push_word(32'h0000_000B, 1);
    cfg(FIX_050, 1, 2);
    wait_run("t2", 100);

    // Rejected configs, then a stalled run clears err_cfg
    cfg(32'h0, 0, 3);
    @(negedge clk);
    chk("rej_seed_err", err_cfg, 1);
    chk("rej_seed_rdy", cfg_ready, 1);
    chk("rej_seed_busy", busy, 0);
    #1;
    cfg(32'h1234_5678, 2, 0);
    @(negedge clk);
    chk("rej_len_err", err_cfg, 1);
    chk("rej_len_busy", busy, 0);
    #1;
    rdy_mode = 1;
    push_word(FIX_075, 0);
    push_word(FIX_075 - 1, 0);
    push_word(FIX_075 + 1, 1);
    cfg(32'h4000_0000, 0, 3);
    @(negedge clk);
    chk("err_cleared", err_cfg, 0);
    wait_run("t4_stall", 200);

    // Abort during WARM
    rdy_mode = 0;
    #1;
    d0 = done_cnt;
    cfg(32'h1357_9BDF, 5, 2);
    repeat (3) @(posedge clk);
    #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    chk("abw_busy", busy, 0);
    chk("abw_rdy", cfg_ready, 1);
    chk("abw_err", err_cfg, 0);
    repeat (20) @(posedge clk);
    chk("abw_no_done", done_cnt, d0);

    // Abort in EMIT with ks_ready high
    #1;
    d0 = done_cnt;
    cfg(32'h4000_0000, 0, 3);
    wait_valid(50);
    abort = 1;
    @(posedge clk); #1 abort = 0;
    chk("abe_valid", ks_valid, 0);
    chk("abe_last", ks_last, 0);
    chk("abe_busy", busy, 0);
    repeat (10) @(posedge clk);
    chk("abe_no_done", done_cnt, d0);
    #1;
    run_t1("abe_restart");

    // rst mid-EMIT while stalled
    rdy_mode = 1;
    #1;
    cfg(32'h4000_0000, 0, 3);
    wait_valid(50);
    rst = 1;
    @(posedge clk); #1;
    chk_reset_outs("rst_mid");
    rst = 0;
    exp_q.delete();
    rdy_mode = 0;
    run_t1("rst_rerun");

    // Randomized runs with random backpressure
    rdy_mode = 2;
    for (int k = 0; k < 10; k++) begin
      s = $urandom;
      if (s == 0) s = 32'h1;
      w = $urandom_range(0, 6);
      l = $urandom_range(1, 5);
      #1;
      model_push(s, w, l);
      cfg(s, 16'(w), 16'(l));
      wait_run("rand", 400);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 want 0");
    $fatal(1, "timeout");
  end

endmodule
